team_06_esp_tx_framer: RTL
==========================

# team_06_esp_tx_framer

Upstream stage of `team_06_spi_to_esp`. Accepts payload bytes from the rest of the team_06 design over a valid/ready handshake and buffers one message of up to 16 bytes. It then presents a framed byte stream on the serializer's `parallel_in`/`cs` inputs: header, length, payload, checksum. Each byte is held for a fixed number of clocks so the serializer can shift it out, and frames are separated by a `cs`-low gap.

## Interface
- `BYTE_CYCLES`, 8: clocks each framed byte is held on `parallel_out`; matches serializer shift time; ≥2.
- `GAP_CYCLES`, 4: clocks `cs_out` stays low after a frame before new input is accepted; ≥1.
- `DEPTH`, 16: payload buffer depth in bytes; power of two, ≤255.
- `HEADER`, 8'hA5: first byte of every frame.
- `clk` input 1: single system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data_in` input 8: payload byte.
- `data_valid` input 1: `data_in` is valid this cycle.
- `data_last` input 1: qualifies `data_in` as the final byte of the message; ignored unless `data_valid`.
- `data_ready` output 1: block accepts a byte this cycle; a transfer occurs when `data_valid & data_ready`.
- `parallel_out` output 8: byte to serializer `parallel_in`.
- `cs_out` output 1: to serializer `cs`; high for the whole frame.
- `frame_done` output 1: one-cycle pulse at end of inter-frame gap.

## Operation
- State machine states and transitions:
  - IDLE → FILL on the first accepted byte.
  - IDLE or FILL → HDR when a byte with `data_last` is accepted, or when the DEPTH-th byte is accepted. The DEPTH-th byte is treated as an implicit last.
  - HDR → LEN → PAY → CSUM: each transition occurs on byte-timer wrap.
  - PAY stays in PAY until all N bytes have been sent.
  - CSUM → GAP on byte-timer wrap.
  - GAP → IDLE after GAP_CYCLES.
- `data_ready` is 1 only in IDLE/FILL and `rst` low. Input presented in HDR..GAP is not accepted and not stored; the source must hold it.
- Buffer: write pointer increments per accepted byte. Count N is 1..DEPTH and is latched on entry to HDR. The read pointer starts at 0 in PAY.
- Frame byte order: `HEADER`, N (8-bit), payload[0..N-1], checksum.
- Checksum = (N + Σpayload) mod 256, 8-bit wrap-around add.
  - It is accumulated as bytes are accepted, seeded with 0 on IDLE→FILL.
  - N is added at HDR entry.
- Byte timer: counts 0..BYTE_CYCLES-1 and resets to 0 on entry to HDR. `parallel_out` updates only when the timer wraps.
- `cs_out` = 1 exactly in HDR, LEN, PAY, CSUM; 0 otherwise.
- `parallel_out` in IDLE/FILL/GAP holds 8'h00.
- Reset mid-frame: the next edge with `rst`=1 returns the block to IDLE. The buffer count and checksum are cleared. The partial frame is abandoned and `cs_out` drops on that edge.

## Timing
- Reset values: `parallel_out`=8'h00, `cs_out`=0, `frame_done`=0, `data_ready`=0 while `rst`=1. `data_ready`=1 in the first cycle after `rst` deasserts.
- Last byte accepted at edge t:
  - `cs_out`=1 and `parallel_out`=`HEADER` are registered at edge t+1.
  - Length appears at t+1+BYTE_CYCLES.
  - Payload[k] appears at t+1+(2+k)·BYTE_CYCLES.
- `cs_out` is high for exactly (N+3)·BYTE_CYCLES cycles. It is then low for GAP_CYCLES cycles.
- `frame_done` pulses in the final GAP cycle. `data_ready` returns to 1 the cycle after that.
- Byte and last accepted in the same cycle as the DEPTH-th byte: one frame with N=DEPTH.

## Test plan
- Send 0x01,0x02,0x03 (last on 0x03), default parameters → `cs_out` high 48 cycles. `parallel_out` sequence A5,03,01,02,03,09, each held 8 cycles. `frame_done` pulses 4 cycles after `cs_out` falls.
- Single byte 0xFF with `data_last` from IDLE → frame A5,01,FF,00; `cs_out` high 32 cycles.
- 16 bytes 0x10..0x1F, no `data_last` → frame starts the cycle after the 16th byte. Length 0x10, checksum 0x10+0x178 mod 256 = 0x88.
- Hold `data_valid`=1 with 0x55 throughout a frame → `data_ready`=0 from HDR through GAP, no 0x55 stored. 0x55 is accepted the first cycle `data_ready` returns.
- Assert `rst` for 1 cycle during PAY → `cs_out`=0 and `parallel_out`=00 next edge. A following message 0x07 (last) frames as A5,01,07,08.
- `data_last` high with `data_valid` low in IDLE → no state change, `cs_out` stays 0.

Source files
------------

// File: rtl/team_06_esp_tx_framer.sv
// ESP transmit framer: buffers one message, then emits header, length,
// payload and checksum bytes to the serializer with a cs-low gap after.
module team_06_esp_tx_framer #(
  parameter int         BYTE_CYCLES = 8,
  parameter int         GAP_CYCLES  = 4,
  parameter int         DEPTH       = 16,
  parameter logic [7:0] HEADER      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic [7:0] parallel_out,
  output logic       cs_out,
  output logic       frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_HDR, S_LEN,
    S_PAY, S_CSUM, S_GAP
  } state_e;

  state_e state_q, state_d;
  logic [7:0] wr_q, wr_d;
  logic [7:0] n_q, n_d;
  logic [7:0] rd_q, rd_d;
  logic [7:0] sum_q, sum_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0] pout_q, pout_d;
  logic cs_q, cs_d;
  logic [7:0] mem_q [DEPTH];

  logic acc, wrap, last, in_frame;
  logic [7:0] cnt_inc, acc_sum;

  assign data_ready = !rst &&
    (state_q == S_IDLE || state_q == S_FILL);
  assign frame_done = !rst && state_q == S_GAP &&
    tmr_q == TW'(GAP_CYCLES);
  assign parallel_out = pout_q;
  assign cs_out = cs_q;

  always_comb begin
    acc = data_valid & data_ready;
    wrap = tmr_q == TW'(BYTE_CYCLES - 1);
    in_frame = state_q == S_HDR || state_q == S_LEN ||
      state_q == S_PAY || state_q == S_CSUM;
    cnt_inc = wr_q + 8'd1;
    // the DEPTH-th byte closes the message even without data_last
    last = data_last | (cnt_inc == 8'(DEPTH));
    acc_sum = (state_q == S_IDLE ? 8'h00 : sum_q) + data_in;
    state_d = state_q;
    wr_d = wr_q;
    n_d = n_q;
    rd_d = rd_q;
    sum_d = sum_q;
    tmr_d = tmr_q + TW'(1);
    cs_d = in_frame;
    pout_d = in_frame ? pout_q : 8'h00;
    unique case (state_q)
      S_IDLE, S_FILL: begin
        tmr_d = '0;
        if (acc) begin
          wr_d = cnt_inc;
          sum_d = acc_sum;
          state_d = S_FILL;
          if (last) begin
            state_d = S_HDR;
            n_d = cnt_inc;
            sum_d = acc_sum + cnt_inc;
            rd_d = 8'd0;
          end
        end
      end
      S_HDR: begin
        if (tmr_q == '0) pout_d = HEADER;
        if (wrap) begin
          state_d = S_LEN;
          tmr_d = '0;
        end
      end
      S_LEN: begin
        if (tmr_q == '0) pout_d = n_q;
        if (wrap) begin
          state_d = S_PAY;
          tmr_d = '0;
        end
      end
      S_PAY: begin
        if (tmr_q == '0) pout_d = mem_q[rd_q[AW-1:0]];
        if (wrap) begin
          tmr_d = '0;
          if (rd_q == n_q - 8'd1) state_d = S_CSUM;
          else rd_d = rd_q + 8'd1;
        end
      end
      S_CSUM: begin
        if (tmr_q == '0) pout_d = sum_q;
        if (wrap) begin
          state_d = S_GAP;
          tmr_d = '0;
        end
      end
      S_GAP: begin
        wr_d = 8'd0;
        if (tmr_q == TW'(GAP_CYCLES)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q <= 8'd0;
      n_q <= 8'd0;
      rd_q <= 8'd0;
      sum_q <= 8'd0;
      tmr_q <= '0;
      pout_q <= 8'h00;
      cs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      n_q <= n_d;
      rd_q <= rd_d;
      sum_q <= sum_d;
      tmr_q <= tmr_d;
      pout_q <= pout_d;
      cs_q <= cs_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_q[AW-1:0]] <= data_in;
  end

endmodule
